// File: rtl/sw_pkg.sv
// Shared constants and types for the switch input-conditioning block.
package sw_pkg;

  localparam int SW_N_CH           = 4;
  localparam int SW_SYNC_STAGES    = 2;
  // 10 ms at 100 MHz
  localparam int SW_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } ch_state_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: synchroniser, consecutive-sample debounce counter,
// clean level register and registered rise/fall pulses.
module sw_debounce_ch
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic debounce_en,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Acceptance happens at this value, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sw_debounce_ch: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("sw_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;

  ch_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             clean, clean_next;
  logic             rise, rise_next;
  logic             fall, fall_next;

  assign sync = sync_chain[SYNC_STAGES-1];

  // Plain flop chain into clk; nothing between stages.
  always_ff @(posedge clk) begin
    if (!resetn) sync_chain <= '0;
    else         sync_chain <= {sync_chain[SYNC_STAGES-2:0], sw_raw};
  end

  // State, counter, clean level and pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= STABLE;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      clean <= clean_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Next-state: bypass tracks sync directly; otherwise count consecutive
  // differing samples and accept on the terminal count.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clean_next = clean;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (!debounce_en) begin
      state_next = STABLE;
      cnt_next   = '0;
      clean_next = sync;
      rise_next  = sync & ~clean;
      fall_next  = ~sync & clean;
    end else begin
      unique case (state)
        STABLE: begin
          if (sync != clean) begin
            state_next = PENDING;
            cnt_next   = CNT_W'(1);
          end
        end
        PENDING: begin
          if (sync == clean) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt == CNT_TERM) begin
            state_next = STABLE;
            cnt_next   = '0;
            clean_next = sync;
            rise_next  = sync;
            fall_next  = ~sync;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = STABLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign sw_clean = clean;
  assign sw_rise  = rise;
  assign sw_fall  = fall;

endmodule

// File: rtl/sw_debounce_x4.sv
// Input conditioning for the 4-switch controller: N_CH independent
// synchronise-and-debounce channels with edge pulses.
module sw_debounce_x4
  import sw_pkg::*;
#(
  parameter int N_CH            = SW_N_CH,
  parameter int SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            debounce_en,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
);

  // One fully independent channel per switch pin.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .debounce_en(debounce_en),
      .sw_raw     (sw_raw[i]),
      .sw_clean   (sw_clean[i]),
      .sw_rise    (sw_rise[i]),
      .sw_fall    (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce_x4.sv
// Bench for sw_debounce_x4 with SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
module tb_sw_debounce_x4;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         debounce_en;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_clean, sw_rise, sw_fall;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int rise_cnt [N];
  int fall_cnt [N];

  sw_debounce_x4 #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .debounce_en(debounce_en),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: the synchronised sample is the raw input seen SYNC
  // edges ago; a new level is taken once DEB consecutive samples differ
  // from the current clean level (or immediately in bypass).
  logic [SYNC-1:0] hist [N];
  int              run  [N];
  logic [N-1:0]    m_clean = '0, m_rise = '0, m_fall = '0;
  logic            s, old;

  always @(posedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      if (!resetn) begin
        hist[ch]    = '0;
        run[ch]     = 0;
        m_clean[ch] = 1'b0;
        m_rise[ch]  = 1'b0;
        m_fall[ch]  = 1'b0;
      end else begin
        s   = hist[ch][SYNC-1];
        old = m_clean[ch];
        if (!debounce_en) begin
          run[ch]     = 0;
          m_clean[ch] = s;
        end else if (s != old) begin
          run[ch] = run[ch] + 1;
          if (run[ch] == DEB) begin
            m_clean[ch] = s;
            run[ch]     = 0;
          end
        end else begin
          run[ch] = 0;
        end
        m_rise[ch] = m_clean[ch] & ~old;
        m_fall[ch] = ~m_clean[ch] & old;
        hist[ch]   = {hist[ch][SYNC-2:0], sw_raw[ch]};
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse tallies.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_clean", 32'(sw_clean), 32'(m_clean));
      chk("model_rise",  32'(sw_rise),  32'(m_rise));
      chk("model_fall",  32'(sw_fall),  32'(m_fall));
      chk("rise_and_fall", 32'(sw_rise & sw_fall), 32'd0);
      for (int ch = 0; ch < N; ch++) begin
        if (sw_rise[ch]) rise_cnt[ch]++;
        if (sw_fall[ch]) fall_cnt[ch]++;
      end
    end
  end

  int r0;

  initial begin
    for (int ch = 0; ch < N; ch++) begin
      rise_cnt[ch] = 0;
      fall_cnt[ch] = 0;
    end
    resetn      = 1'b0;
    debounce_en = 1'b1;
    sw_raw      = '0;
    cycles(2);
    chk_on = 1'b1;
    chk("reset_clean", 32'(sw_clean), 32'd0);
    chk("reset_rise",  32'(sw_rise),  32'd0);
    chk("reset_fall",  32'(sw_fall),  32'd0);
    resetn = 1'b1;

    // 1. Idle
    cycles(50);
    chk("idle_clean", 32'(sw_clean), 32'd0);
    chk("idle_pulses", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
                           + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'd0);

    // 2. Clean rise on channel 0
    sw_raw = 4'b0001;
    cycles(9);
    chk("rise0_edge9_clean", 32'(sw_clean), 32'h0);
    cycles(1);
    chk("rise0_edge10_clean", 32'(sw_clean), 32'h1);
    chk("rise0_edge10_pulse", 32'(sw_rise), 32'h1);
    cycles(1);
    chk("rise0_pulse_gone", 32'(sw_rise), 32'h0);

    // 3. Bounce then settle on channel 1
    r0 = rise_cnt[1];
    sw_raw[1] = 1'b1; cycles(5);
    sw_raw[1] = 1'b0; cycles(5);
    sw_raw[1] = 1'b1; cycles(3);
    sw_raw[1] = 1'b0; cycles(3);
    sw_raw[1] = 1'b1; cycles(6);
    sw_raw[1] = 1'b0; cycles(6);
    chk("bounce_clean", 32'(sw_clean), 32'h1);
    sw_raw[1] = 1'b1;
    cycles(9);
    chk("settle_edge9_clean", 32'(sw_clean), 32'h1);
    cycles(1);
    chk("settle_edge10_clean", 32'(sw_clean), 32'h3);
    chk("settle_edge10_rise", 32'(sw_rise), 32'h2);
    cycles(2);
    chk("settle_rise_count", 32'(rise_cnt[1] - r0), 32'd1);

    // 4. Fall on all channels from 1111
    sw_raw = 4'b1111;
    cycles(12);
    chk("all_high_clean", 32'(sw_clean), 32'hF);
    sw_raw = 4'b0000;
    cycles(9);
    chk("fall_edge9_clean", 32'(sw_clean), 32'hF);
    cycles(1);
    chk("fall_edge10_clean", 32'(sw_clean), 32'h0);
    chk("fall_edge10_fall", 32'(sw_fall), 32'hF);
    chk("fall_edge10_rise", 32'(sw_rise), 32'h0);
    cycles(3);

    // 5. Bypass: one-cycle glitch on channel 2
    debounce_en = 1'b0;
    cycles(2);
    sw_raw = 4'b0100;
    cycles(1);
    sw_raw = 4'b0000;
    cycles(1);
    chk("bypass_edge2_clean", 32'(sw_clean), 32'h0);
    cycles(1);
    chk("bypass_edge3_clean", 32'(sw_clean), 32'h4);
    chk("bypass_edge3_rise", 32'(sw_rise), 32'h4);
    cycles(1);
    chk("bypass_edge4_clean", 32'(sw_clean), 32'h0);
    chk("bypass_edge4_fall", 32'(sw_fall), 32'h4);
    debounce_en = 1'b1;
    cycles(4);

    // 6. Reset mid-count on channel 3
    sw_raw = 4'b1000;
    cycles(7);
    resetn = 1'b0;
    cycles(1);
    chk("midreset_clean", 32'(sw_clean), 32'h0);
    chk("midreset_rise", 32'(sw_rise), 32'h0);
    cycles(2);
    resetn = 1'b1;
    cycles(3);
    chk("after_release_edge3", 32'(sw_clean), 32'h0);
    cycles(6);
    chk("after_release_edge9", 32'(sw_clean), 32'h0);
    cycles(1);
    chk("after_release_edge10_clean", 32'(sw_clean), 32'h8);
    chk("after_release_edge10_rise", 32'(sw_rise), 32'h8);
    cycles(3);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce_x4.md
# sw_debounce_x4

Input-conditioning stage for the 4-switch controller. It takes the raw, asynchronous, bouncing switch pins and synchronises each one into `clk`. It then debounces each channel with a consecutive-sample counter and presents a clean, glitch-free level vector that drives the controller's `SW` input directly. It also emits one-cycle rise/fall pulses per channel for any logic that wants edges without re-deriving them.

## Interface
Parameters:
- `N_CH`, 4, number of switch channels.
- `SYNC_STAGES`, 2, synchroniser flop depth. Must be ≥2.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive differing samples required to accept a new level (10 ms at 100 MHz). Must be ≥2.

Ports:
- `clk`, in, 1, system clock.
- `resetn`, in, 1, synchronous, active-low reset.
- `debounce_en`, in, 1, 1 = debounce active; 0 = bypass (clean follows synchronised input).
- `sw_raw`, in, N_CH, asynchronous switch pins.
- `sw_clean`, out, N_CH, debounced level. Feeds the controller `SW`.
- `sw_rise`, out, N_CH, one-cycle pulse when `sw_clean[i]` goes 0→1.
- `sw_fall`, out, N_CH, one-cycle pulse when `sw_clean[i]` goes 1→0.

## Operation
Channels are fully independent; everything below applies per channel `i`.
- **Synchroniser**
  - `SYNC_STAGES` flops in series; `sync[i]` is the last stage.
  - No logic between the stages.
- **Per-channel states**
  - STABLE: `sync == clean`. Counter is 0.
  - PENDING: `sync != clean`. Counter increments each cycle.
- **Transitions**
  - STABLE→PENDING: first sample with `sync != clean`; counter ← 1.
  - PENDING→STABLE (bounce): `sync == clean` again; counter ← 0. `clean` and pulses are unchanged.
  - PENDING→STABLE (accept): when `sync != clean` and counter == DEBOUNCE_CYCLES−1:
    - `clean` ← `sync` and counter ← 0 on that edge;
    - the rise or fall pulse is registered on the same edge.
- **Counter width**: `$clog2(DEBOUNCE_CYCLES)`. It never wraps, because acceptance occurs at the terminal value.
- **Bypass** (`debounce_en` = 0):
  - counter forced to 0;
  - `clean` ← `sync` every cycle;
  - rise/fall pulses are still generated on every `clean` change.
- **Enabling debounce**: when `debounce_en` goes 0→1 mid-operation, the block starts from STABLE with counter 0.
- **Reset**: reset mid-count discards partial progress.
- **Startup**: after reset, a switch that is already high is accepted as a normal rise, one full debounce period later, and produces one `sw_rise` pulse.
- **Out-of-range parameters**: elaboration-time assertion fails if `SYNC_STAGES` < 2 or `DEBOUNCE_CYCLES` < 2.

## Timing
- **Reset values**: `sw_clean` = 0, `sw_rise` = 0, `sw_fall` = 0, all sync flops = 0, all counters = 0.
- **Latency, debounce on**: a clean raw step is reflected on `sw_clean` at the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge, counting the capturing edge as 1.
- **Latency, bypass**: SYNC_STAGES + 1 edges.
- **Pulses**
  - `sw_rise`/`sw_fall` are high exactly one cycle, coincident with the first cycle of the new `sw_clean` value.
  - Rise and fall are never both high on one channel.
- **Outputs**: all registered; no combinational path from `sw_raw` or `debounce_en` to any output.
- **Minimum toggle period**: a clean level held ≥ DEBOUNCE_CYCLES samples is always accepted. Toggles shorter than that are filtered entirely.

## Structure
- **Package `sw_pkg`**: channel-count constant `SW_N_CH` = 4, default debounce constant, and the per-channel state enum {STABLE, PENDING}.
- **Sub-module `sw_debounce_ch`**: one channel, holding the synchroniser, counter, state and pulse registers.
- **Top level**: instantiates `sw_debounce_ch` N_CH times in a generate loop, with no shared state between channels.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=8.
1. **Idle**: reset, `sw_raw`=0000 held 50 cycles → `sw_clean`=0000, no pulses.
2. **Clean rise**: `sw_raw[0]` 0→1 held → `sw_clean[0]`=1 at the 10th edge. `sw_rise[0]` high that cycle only. Other channels unchanged.
3. **Bounce then settle**: `sw_raw[1]` toggles with periods of 5, 3 and 6 high/low, then is held 1 → no `sw_clean` change during bouncing. The rise occurs 10 edges after the final 0→1 step, with exactly one `sw_rise[1]` pulse.
4. **Fall, all channels**: from 1111, `sw_raw`=0000 simultaneously → all `sw_fall` bits pulse on the same cycle. `sw_clean`=0000 and no `sw_rise`.
5. **Bypass**: `debounce_en`=0, `sw_raw[2]` 1-cycle glitch → `sw_clean[2]` shows a 1-cycle high 3 edges later, with a rise pulse followed by a fall pulse.
6. **Reset mid-count**: `sw_raw[3]`=1, assert `resetn`=0 after counter reaches 5, release → outputs 0 during reset. After release `sw_clean[3]` rises 10 edges after the release edge, not earlier.
